// File: rtl/mux_nto1_skid_if.sv
// Handshake bundle for mux_nto1_skid: selectable input side, registered output side.
// The slave modport is the mux itself, the master modport is whoever drives and drains it.
interface mux_nto1_skid_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    modport slave (
        input  in_data, in_sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err
    );

    modport master (
        output in_data, in_sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err
    );
endinterface

// File: rtl/mux_nto1_skid.sv
// NUM_IN-to-1 operand mux with a registered output and a one-entry skid buffer.
// Optional sticky out-of-range select flag: define MUX_SEL_CHECK_EN.
module mux_nto1_skid #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input logic             CLK,
    input logic             RESET_N,
    mux_nto1_skid_if.slave  bus
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Any index at or beyond the last input falls back to the last input.
    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
        return (s >= LAST_SEL) ? LAST_SEL : s;
    endfunction

    function automatic logic [WIDTH-1:0] pick_data(
        input logic [NUM_IN*WIDTH-1:0] d,
        input logic [SEL_W-1:0]        s
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (s == SEL_W'(i)) r = d[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    state_t           state;
    logic             rdy_q;
    logic [SEL_W-1:0] sel_p0;
    logic [WIDTH-1:0] data_p0;
    logic             vld_p1;
    logic [SEL_W-1:0] sel_p1;
    logic [WIDTH-1:0] data_p1;
    logic             skid_vld_p1;
    logic [SEL_W-1:0] skid_sel_p1;
    logic [WIDTH-1:0] skid_data_p1;
    logic             accept;
    logic             emit;

    // Stage 0: combinational select on the incoming beat
    assign sel_p0  = clamp_sel(bus.in_sel);
    assign data_p0 = pick_data(bus.in_data, sel_p0);

    assign accept = bus.in_valid & rdy_q;
    assign emit   = vld_p1 & bus.out_ready;

    // Stage 1: output register plus parallel skid register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= EMPTY;
            rdy_q       <= 1'b1;
            vld_p1      <= 1'b0;
            sel_p1      <= '0;
            data_p1     <= '0;
            skid_vld_p1 <= 1'b0;
        end else if (bus.flush) begin
            state       <= EMPTY;
            rdy_q       <= 1'b1;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        data_p1 <= data_p0;
                        sel_p1  <= sel_p0;
                        vld_p1  <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        data_p1 <= data_p0;
                        sel_p1  <= sel_p0;
                    end else if (emit) begin
                        vld_p1 <= 1'b0;
                        state  <= EMPTY;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat so in_ready can drop a cycle late.
                        skid_data_p1 <= data_p0;
                        skid_sel_p1  <= sel_p0;
                        skid_vld_p1  <= 1'b1;
                        rdy_q        <= 1'b0;
                        state        <= FULL;
                    end
                end
                FULL: begin
                    if (emit) begin
                        data_p1     <= skid_data_p1;
                        sel_p1      <= skid_sel_p1;
                        skid_vld_p1 <= 1'b0;
                        rdy_q       <= 1'b1;
                        state       <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    rdy_q       <= 1'b1;
                    vld_p1      <= 1'b0;
                    skid_vld_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_sel   = sel_p1;

`ifdef MUX_SEL_CHECK_EN
    logic sel_err_q;
    logic sel_oob;

    assign sel_oob = accept & ~bus.flush & (int'(bus.in_sel) >= NUM_IN);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sel_err_q <= 1'b0;
        end else if (sel_oob) begin
            sel_err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RESET_N && sel_oob)
            $display("mux_nto1_skid: warning, select %0d out of range, using %0d",
                     bus.in_sel, NUM_IN - 1);
    end
`endif

    assign bus.sel_err = sel_err_q;
`else
    assign bus.sel_err = 1'b0;
`endif

`ifndef SYNTHESIS
    a_hold_stable: assert property (@(posedge CLK) disable iff (!RESET_N)
        (vld_p1 && !bus.out_ready && !bus.flush) |=> (vld_p1 && $stable(data_p1) && $stable(sel_p1)));
    a_ready_vs_skid: assert property (@(posedge CLK) disable iff (!RESET_N)
        rdy_q == !skid_vld_p1);
`endif

endmodule

// File: tb/tb_mux_nto1_skid.sv
// Directed and scoreboard-driven checks of mux_nto1_skid, default and 8-bit/5-input builds.
module tb_mux_nto1_skid;

    logic CLK;
    logic RESET_N;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  sel;
    } beat_t;

    beat_t q[$];

    localparam logic [95:0] WORDS3 = {32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [39:0] WORDS5 = {8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};

    mux_nto1_skid_if #(.WIDTH(32), .NUM_IN(3)) bus ();
    mux_nto1_skid_if #(.WIDTH(8),  .NUM_IN(5)) bus5 ();

    mux_nto1_skid #(.WIDTH(32), .NUM_IN(3)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
    );
    mux_nto1_skid #(.WIDTH(8), .NUM_IN(5)) dut5 (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (2) step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data); end
        checks++; if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", bus.out_sel); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.in_ready); end
        checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL reset_selerr got %0b want 0", bus.sel_err); end
        checks++; if (bus5.out_valid !== 1'b0) begin errors++; $display("FAIL reset5_valid got %0b want 0", bus5.out_valid); end
        RESET_N = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL idle got valid=%0b ready=%0b want 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_d [4];
        logic [1:0]  exp_s [4];
        exp_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd2};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_sel = 2'(i);
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i] || bus.out_sel !== exp_s[i]) begin
                errors++; $display("FAIL stream_%0d got v=%0b d=%h s=%0d want 1/%h/%0d",
                                   i, bus.out_valid, bus.out_data, bus.out_sel, exp_d[i], exp_s[i]); end
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %0b want 1", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        step();
        checks++; if (bus.out_data !== 32'h11111111 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_a got d=%h r=%0b want 11111111/1", bus.out_data, bus.in_ready); end
        bus.in_sel = 2'd1;
        step();
        checks++; if (bus.out_data !== 32'h11111111 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full got d=%h r=%0b want 11111111/0", bus.out_data, bus.in_ready); end
        bus.in_sel = 2'd2;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11111111 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold got v=%0b d=%h r=%0b want 1/11111111/0", bus.out_valid, bus.out_data, bus.in_ready); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_data !== 32'h22222222 || bus.out_sel !== 2'd1 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_b got d=%h s=%0d r=%0b want 22222222/1/1", bus.out_data, bus.out_sel, bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h33333333 || bus.out_sel !== 2'd2) begin
            errors++; $display("FAIL bp_c got v=%0b d=%h s=%0d want 1/33333333/2", bus.out_valid, bus.out_data, bus.out_sel); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        step();
        bus.in_sel = 2'd1;
        step();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup got ready=%0b want 0", bus.in_ready); end
        bus.in_sel = 2'd2;
        bus.flush  = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full got v=%0b r=%0b want 0/1", bus.out_valid, bus.in_ready); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got %0b want 0", bus.out_valid); end
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_param();
        logic exp_err;
`ifdef MUX_SEL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        bus5.out_ready = 1'b1;
        bus5.in_valid  = 1'b1;
        bus5.in_sel    = 3'd4;
        step();
        checks++; if (bus5.out_data !== 8'hA5 || bus5.out_sel !== 3'd4 || bus5.out_valid !== 1'b1) begin
            errors++; $display("FAIL p_sel4 got d=%h s=%0d v=%0b want a5/4/1", bus5.out_data, bus5.out_sel, bus5.out_valid); end
        checks++; if (bus5.sel_err !== 1'b0) begin errors++; $display("FAIL p_err_inrange got %0b want 0", bus5.sel_err); end
        bus5.in_sel = 3'd2;
        step();
        checks++; if (bus5.out_data !== 8'h33 || bus5.out_sel !== 3'd2) begin
            errors++; $display("FAIL p_sel2 got d=%h s=%0d want 33/2", bus5.out_data, bus5.out_sel); end
        bus5.in_sel = 3'd7;
        step();
        bus5.in_valid = 1'b0;
        checks++; if (bus5.out_data !== 8'hA5 || bus5.out_sel !== 3'd4) begin
            errors++; $display("FAIL p_sel7 got d=%h s=%0d want a5/4", bus5.out_data, bus5.out_sel); end
        checks++; if (bus5.sel_err !== exp_err) begin errors++; $display("FAIL p_err got %0b want %0b", bus5.sel_err, exp_err); end
        bus5.flush = 1'b1;
        step();
        bus5.flush = 1'b0;
        checks++; if (bus5.sel_err !== exp_err || bus5.out_valid !== 1'b0) begin
            errors++; $display("FAIL p_err_flush got e=%0b v=%0b want %0b/0", bus5.sel_err, bus5.out_valid, exp_err); end
    endtask

    task automatic test_random();
        beat_t item;
        logic  acc, emt;
        logic [1:0] idx;
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bus.in_data   = {$urandom(), $urandom(), $urandom()};
            bus.in_sel    = 2'($urandom_range(0, 3));
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.flush     = ($urandom_range(0, 31) == 0);
            idx           = (bus.in_sel >= 2'd2) ? 2'd2 : bus.in_sel;
            item.sel      = idx;
            item.data     = bus.in_data[32*idx +: 32];
            acc = bus.in_valid && (q.size() < 2) && !bus.flush;
            emt = (q.size() > 0) && bus.out_ready && !bus.flush;
            step();
            if (bus.flush) q.delete();
            else begin
                if (emt) void'(q.pop_front());
                if (acc) q.push_back(item);
            end
            checks++; if (bus.out_valid !== (q.size() > 0)) begin
                errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, bus.out_valid, q.size() > 0); end
            checks++; if (bus.in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", cyc, bus.in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                checks++; if (bus.out_data !== q[0].data || bus.out_sel !== q[0].sel) begin
                    errors++; $display("FAIL rnd_data cyc %0d got %h/%0d want %h/%0d",
                                       cyc, bus.out_data, bus.out_sel, q[0].data, q[0].sel); end
            end
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET_N = 1'b0;
        bus.in_data   = WORDS3;
        bus.in_sel    = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus5.in_data   = WORDS5;
        bus5.in_sel    = '0;
        bus5.in_valid  = 1'b0;
        bus5.flush     = 1'b0;
        bus5.out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_back_to_back();
        test_flush();
        test_param();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
